// File: rtl/ltssm_substate_sequencer_if.sv
// Sequencer <-> Rx/Tx sub-LTSSM signal bundle.
// The master is the sequencer; the slave side is the Rx/Tx pair plus control.
interface ltssm_substate_sequencer_if;
  logic       forceDetect;
  logic       rxFinish;
  logic [4:0] rxExitTo;
  logic       txFinish;
  logic [2:0] trainToGen;
  logic [4:0] substate;
  logic       startRx;
  logic       startTx;
  logic [2:0] gen;
  logic       linkUp;
  logic       errPulse;

  modport master (
    input  forceDetect, rxFinish, rxExitTo, txFinish, trainToGen,
    output substate, startRx, startTx, gen, linkUp, errPulse
  );

  modport slave (
    output forceDetect, rxFinish, rxExitTo, txFinish, trainToGen,
    input  substate, startRx, startTx, gen, linkUp, errPulse
  );
endinterface

// File: rtl/ltssm_substate_sequencer.sv
// Top-level LTSSM sequencer: launches each substate on the Rx/Tx sub-LTSSMs,
// joins their finish handshakes, tracks gen and falls back to Detect.Quiet on errors.
module ltssm_substate_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_GEN        = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  ltssm_substate_sequencer_if.master    bus
);

  localparam logic [4:0]  SUB_DETECT_QUIET = 5'd0;
  localparam logic [4:0]  SUB_L0           = 5'd10;
  localparam logic [4:0]  SUB_REC_SPEED    = 5'd12;
  localparam logic [4:0]  SUB_MAX_LEGAL    = 5'd14;
  localparam logic [2:0]  GEN_DEFAULT      = 3'd1;
  localparam logic [2:0]  MAX_GEN_L        = (MAX_GEN > 7) ? 3'd7 : 3'(MAX_GEN);
  localparam logic [15:0] WDOG_LAST        = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic {ST_LAUNCH, ST_WAIT} seqState_e;

  seqState_e   stateReg, stateNext;
  logic [4:0]  substateReg, substateNext;
  logic [2:0]  genReg, genNext;
  logic        rxDoneReg, rxDoneNext;
  logic        txDoneReg, txDoneNext;
  logic [4:0]  nextSubReg, nextSubNext;
  logic [15:0] wdogReg, wdogNext;
  logic        startReg, startNext;
  logic        errReg, errNext;
  logic        linkUpReg, linkUpNext;

  logic        joinNow;
  logic [4:0]  joinTarget;
  logic        genReqOk;

  // A finish arriving in the join cycle itself counts, and its exitTo beats the latched one.
  assign joinNow    = (rxDoneReg | bus.rxFinish) & (txDoneReg | bus.txFinish);
  assign joinTarget = bus.rxFinish ? bus.rxExitTo : nextSubReg;
  assign genReqOk   = (bus.trainToGen != 3'd0) && (bus.trainToGen <= MAX_GEN_L);

  always_comb begin
    stateNext    = stateReg;
    substateNext = substateReg;
    genNext      = genReg;
    rxDoneNext   = rxDoneReg;
    txDoneNext   = txDoneReg;
    nextSubNext  = nextSubReg;
    wdogNext     = wdogReg;
    startNext    = 1'b0;
    errNext      = 1'b0;

    if (bus.forceDetect) begin
      substateNext = SUB_DETECT_QUIET;
      genNext      = GEN_DEFAULT;
      stateNext    = ST_LAUNCH;
    end else begin
      case (stateReg)
        ST_LAUNCH: begin
          startNext  = 1'b1;
          rxDoneNext = 1'b0;
          txDoneNext = 1'b0;
          wdogNext   = 16'd0;
          stateNext  = ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.rxFinish) begin
            rxDoneNext  = 1'b1;
            nextSubNext = bus.rxExitTo;
          end
          if (bus.txFinish) begin
            txDoneNext = 1'b1;
          end
          if (joinNow) begin
            stateNext = ST_LAUNCH;
            if (joinTarget > SUB_MAX_LEGAL) begin
              substateNext = SUB_DETECT_QUIET;
              genNext      = GEN_DEFAULT;
              errNext      = 1'b1;
            end else begin
              substateNext = joinTarget;
              if (substateReg == SUB_REC_SPEED && genReqOk) begin
                genNext = bus.trainToGen;
              end
            end
          end else if (substateReg != SUB_L0) begin
            // L0 is allowed to sit indefinitely; every other substate is watched.
            if (wdogReg == WDOG_LAST) begin
              substateNext = SUB_DETECT_QUIET;
              genNext      = GEN_DEFAULT;
              errNext      = 1'b1;
              stateNext    = ST_LAUNCH;
            end else begin
              wdogNext = wdogReg + 16'd1;
            end
          end
        end
        default: stateNext = ST_LAUNCH;
      endcase
    end

    linkUpNext = (substateNext == SUB_L0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg    <= ST_LAUNCH;
      substateReg <= SUB_DETECT_QUIET;
      genReg      <= GEN_DEFAULT;
      rxDoneReg   <= 1'b0;
      txDoneReg   <= 1'b0;
      nextSubReg  <= SUB_DETECT_QUIET;
      wdogReg     <= 16'd0;
      startReg    <= 1'b0;
      errReg      <= 1'b0;
      linkUpReg   <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      substateReg <= substateNext;
      genReg      <= genNext;
      rxDoneReg   <= rxDoneNext;
      txDoneReg   <= txDoneNext;
      nextSubReg  <= nextSubNext;
      wdogReg     <= wdogNext;
      startReg    <= startNext;
      errReg      <= errNext;
      linkUpReg   <= linkUpNext;
    end
  end

  assign bus.substate = substateReg;
  assign bus.gen      = genReg;
  assign bus.startRx  = startReg;
  assign bus.startTx  = startReg;
  assign bus.errPulse = errReg;
  assign bus.linkUp   = linkUpReg;

endmodule
